// File: rtl/snd_regfile_pkg.sv
// Shared constants and helpers for the multi-channel sound register file.
package snd_regfile_pkg;

  localparam logic [3:0] IDX_CMD     = 4'd0;
  localparam logic [3:0] IDX_VRAMADR = 4'd1;
  localparam logic [3:0] IDX_VOLUME  = 4'd2;
  localparam logic [3:0] IDX_LOOP    = 4'd3;
  localparam logic [3:0] IDX_CTRL    = 4'd4;
  localparam logic [3:0] IDX_STATUS  = 4'd5;
  localparam logic [3:0] IDX_MUSIC   = 4'd6;
  localparam logic [3:0] IDX_DELAY   = 4'd7;
  localparam logic [3:0] IDX_IRQEN   = 4'd8;

  localparam int ST_W = 8;

  function automatic logic [31:0] be_merge(input logic [31:0] old,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    for (int n = 0; n < 4; n++) begin
      merged[8*n +: 8] = be[n] ? wdata[8*n +: 8] : old[8*n +: 8];
    end
    return merged;
  endfunction

  function automatic int chw_of(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/snd_regfile_if.sv
// CIF register bus between the bus decoder (master) and the sound register file (slave).
interface snd_regfile_if #(parameter int CHW = 1);

  logic            CIF_SNDSEL;
  logic            CIF_REGREAD;
  logic [3:0]      CIF_REGWRITE;
  logic [CHW+3:0]  CIF_REGADR;
  logic [31:0]     CIF_REGWDATA;
  logic [31:0]     SND_REGRDATA;
  logic            SND_RVALID;

  modport master (
    output CIF_SNDSEL, CIF_REGREAD, CIF_REGWRITE, CIF_REGADR, CIF_REGWDATA,
    input  SND_REGRDATA, SND_RVALID
  );

  modport slave (
    input  CIF_SNDSEL, CIF_REGREAD, CIF_REGWRITE, CIF_REGADR, CIF_REGWDATA,
    output SND_REGRDATA, SND_RVALID
  );

endinterface

// File: rtl/snd_regfile_ch.sv
// One channel's playback registers, START strobe, W1C status and IRQ term.
// Optional double buffering of playback settings under SND_REGFILE_SHADOW_EN.
module snd_regfile_ch
  import snd_regfile_pkg::*;
#(
  parameter int VADRW = 23
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             wr_en,
  input  logic [3:0]       be,
  input  logic [3:0]       idx,
  input  logic [31:0]      wdata,
  input  logic [ST_W-1:0]  hw_event,
  input  logic             hw_frame,
  output logic [31:0]      rd_data,
  output logic [1:0]       cmd,
  output logic [VADRW-1:0] vramadr,
  output logic [7:0]       volume,
  output logic             loop,
  output logic             dem,
  output logic             mute,
  output logic [31:0]      music,
  output logic [31:0]      delay,
  output logic             start,
  output logic             irq_term
);

  logic [1:0]       cmd_q, cmd_d;
  logic             loop_q, loop_d;
  logic [ST_W-1:0]  status_q, status_d;
  logic [ST_W-1:0]  irqen_q, irqen_d;
  logic             start_q, start_d;
  logic [ST_W-1:0]  w1c;

  logic [VADRW-1:0] vram_q, vram_d;
  logic [7:0]       vol_q, vol_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [31:0]      music_q, music_d;
  logic [31:0]      delay_q, delay_d;

  // *_wq is the copy the CPU writes and reads back; *_wd is its next value.
  logic [VADRW-1:0] vram_wq, vram_wd;
  logic [7:0]       vol_wq, vol_wd;
  logic [1:0]       ctrl_wq, ctrl_wd;
  logic [31:0]      music_wq, music_wd;
  logic [31:0]      delay_wq, delay_wd;

  logic [3:0] be0;
  assign be0 = be & 4'b0001;

  always_comb begin
    cmd_d    = cmd_q;
    loop_d   = loop_q;
    irqen_d  = irqen_q;
    vram_wd  = vram_wq;
    vol_wd   = vol_wq;
    ctrl_wd  = ctrl_wq;
    music_wd = music_wq;
    delay_wd = delay_wq;
    start_d  = 1'b0;
    w1c      = '0;
    if (wr_en) begin
      case (idx)
        IDX_CMD: begin
          cmd_d   = 2'(be_merge(32'(cmd_q), wdata, be0));
          start_d = be[0] && (wdata[1:0] != 2'b00);
        end
        IDX_VRAMADR: vram_wd  = VADRW'(be_merge(32'(vram_wq), wdata, be));
        IDX_VOLUME:  vol_wd   = 8'(be_merge(32'(vol_wq), wdata, be0));
        IDX_LOOP:    loop_d   = 1'(be_merge(32'(loop_q), wdata, be0));
        IDX_CTRL:    ctrl_wd  = 2'(be_merge(32'(ctrl_wq), wdata, be0));
        IDX_STATUS:  w1c      = be[0] ? wdata[ST_W-1:0] : '0;
        IDX_MUSIC:   music_wd = be_merge(music_wq, wdata, be);
        IDX_DELAY:   delay_wd = be_merge(delay_wq, wdata, be);
        IDX_IRQEN:   irqen_d  = ST_W'(be_merge(32'(irqen_q), wdata, be0));
        default: ;
      endcase
    end
    // Hardware set is applied after the clear so a coincident event survives.
    status_d = (status_q & ~w1c) | hw_event;
  end

`ifdef SND_REGFILE_SHADOW_EN
  logic [VADRW-1:0] vram_sh_q;
  logic [7:0]       vol_sh_q;
  logic [1:0]       ctrl_sh_q;
  logic [31:0]      music_sh_q;
  logic [31:0]      delay_sh_q;

  assign vram_wq  = vram_sh_q;
  assign vol_wq   = vol_sh_q;
  assign ctrl_wq  = ctrl_sh_q;
  assign music_wq = music_sh_q;
  assign delay_wq = delay_sh_q;

  // Active copies take the pre-edge shadow, so a coincident write waits a frame.
  always_comb begin
    vram_d  = hw_frame ? vram_sh_q  : vram_q;
    vol_d   = hw_frame ? vol_sh_q   : vol_q;
    ctrl_d  = hw_frame ? ctrl_sh_q  : ctrl_q;
    music_d = hw_frame ? music_sh_q : music_q;
    delay_d = hw_frame ? delay_sh_q : delay_q;
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      vram_sh_q  <= '0;
      vol_sh_q   <= '0;
      ctrl_sh_q  <= '0;
      music_sh_q <= '0;
      delay_sh_q <= '0;
    end else begin
      vram_sh_q  <= vram_wd;
      vol_sh_q   <= vol_wd;
      ctrl_sh_q  <= ctrl_wd;
      music_sh_q <= music_wd;
      delay_sh_q <= delay_wd;
    end
  end
`else
  logic unused_frame;
  assign unused_frame = hw_frame;

  assign vram_wq  = vram_q;
  assign vol_wq   = vol_q;
  assign ctrl_wq  = ctrl_q;
  assign music_wq = music_q;
  assign delay_wq = delay_q;

  always_comb begin
    vram_d  = vram_wd;
    vol_d   = vol_wd;
    ctrl_d  = ctrl_wd;
    music_d = music_wd;
    delay_d = delay_wd;
  end
`endif

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      cmd_q    <= '0;
      loop_q   <= 1'b0;
      status_q <= '0;
      irqen_q  <= '0;
      start_q  <= 1'b0;
      vram_q   <= '0;
      vol_q    <= '0;
      ctrl_q   <= '0;
      music_q  <= '0;
      delay_q  <= '0;
    end else begin
      cmd_q    <= cmd_d;
      loop_q   <= loop_d;
      status_q <= status_d;
      irqen_q  <= irqen_d;
      start_q  <= start_d;
      vram_q   <= vram_d;
      vol_q    <= vol_d;
      ctrl_q   <= ctrl_d;
      music_q  <= music_d;
      delay_q  <= delay_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      IDX_CMD:     rd_data = 32'(cmd_q);
      IDX_VRAMADR: rd_data = 32'(vram_wq);
      IDX_VOLUME:  rd_data = 32'(vol_wq);
      IDX_LOOP:    rd_data = 32'(loop_q);
      IDX_CTRL:    rd_data = 32'(ctrl_wq);
      IDX_STATUS:  rd_data = 32'(status_q);
      IDX_MUSIC:   rd_data = music_wq;
      IDX_DELAY:   rd_data = delay_wq;
      IDX_IRQEN:   rd_data = 32'(irqen_q);
      default:     rd_data = '0;
    endcase
  end

  assign cmd      = cmd_q;
  assign vramadr  = vram_q;
  assign volume   = vol_q;
  assign loop     = loop_q;
  assign dem      = ctrl_q[1];
  assign mute     = ctrl_q[0];
  assign music    = music_q;
  assign delay    = delay_q;
  assign start    = start_q;
  assign irq_term = |(status_q & irqen_q);

endmodule

// File: rtl/snd_regfile.sv
// Multi-channel sound register file: CIF decode, registered readback and IRQ.
// Define SND_REGFILE_SHADOW_EN for frame-synchronised shadow registers.
module snd_regfile
  import snd_regfile_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int VADRW = 23
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  snd_regfile_if.slave         cif,
  input  logic [NCH*8-1:0]     HW_EVENT,
  input  logic [NCH-1:0]       HW_FRAME,
  output logic                 SND_IRQ,
  output logic [NCH-1:0]       REG_START,
  output logic [NCH*2-1:0]     REG_CMD,
  output logic [NCH*VADRW-1:0] REG_VRAMADR,
  output logic [NCH*8-1:0]     REG_VOLUME,
  output logic [NCH-1:0]       REG_LOOP,
  output logic [NCH-1:0]       REG_DEM,
  output logic [NCH-1:0]       REG_MUTE,
  output logic [NCH*32-1:0]    REG_MUSIC,
  output logic [NCH*32-1:0]    REG_DELAY
);

  localparam int CHW = chw_of(NCH);

  logic [CHW-1:0] sel_ch;
  logic [3:0]     idx;
  logic           wr_req;
  logic           rd_req;
  logic [31:0]    ch_rd [NCH];
  logic [NCH-1:0] irq_term;
  logic [31:0]    rd_mux;

  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        irq_q, irq_d;

  assign sel_ch = cif.CIF_REGADR[CHW+3:4];
  assign idx    = cif.CIF_REGADR[3:0];
  assign wr_req = cif.CIF_SNDSEL && (cif.CIF_REGWRITE != 4'b0000);
  assign rd_req = cif.CIF_SNDSEL && cif.CIF_REGREAD;

  // Channel numbers without an instance never match, so they read 0 and drop writes.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    snd_regfile_ch #(.VADRW(VADRW)) u_ch (
      .clk      (CLK),
      .rst_x    (RST_X),
      .wr_en    (wr_req && (sel_ch == CHW'(c))),
      .be       (cif.CIF_REGWRITE),
      .idx      (idx),
      .wdata    (cif.CIF_REGWDATA),
      .hw_event (HW_EVENT[c*8 +: 8]),
      .hw_frame (HW_FRAME[c]),
      .rd_data  (ch_rd[c]),
      .cmd      (REG_CMD[c*2 +: 2]),
      .vramadr  (REG_VRAMADR[c*VADRW +: VADRW]),
      .volume   (REG_VOLUME[c*8 +: 8]),
      .loop     (REG_LOOP[c]),
      .dem      (REG_DEM[c]),
      .mute     (REG_MUTE[c]),
      .music    (REG_MUSIC[c*32 +: 32]),
      .delay    (REG_DELAY[c*32 +: 32]),
      .start    (REG_START[c]),
      .irq_term (irq_term[c])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sel_ch == CHW'(c)) rd_mux = ch_rd[c];
    end
    rdata_d  = rd_req ? rd_mux : rdata_q;
    rvalid_d = rd_req;
    irq_d    = |irq_term;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign cif.SND_REGRDATA = rdata_q;
  assign cif.SND_RVALID   = rvalid_q;
  assign SND_IRQ          = irq_q;

endmodule

// File: tb/tb_snd_regfile.sv
// Directed and randomized bench for snd_regfile against a register-array model.
module tb_snd_regfile;

  localparam int NCH   = 3;
  localparam int VADRW = 23;
  localparam int CHW   = 2;
`ifdef SND_REGFILE_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic                 CLK;
  logic                 RST_X;
  logic [NCH*8-1:0]     HW_EVENT;
  logic [NCH-1:0]       HW_FRAME;
  logic                 SND_IRQ;
  logic [NCH-1:0]       REG_START;
  logic [NCH*2-1:0]     REG_CMD;
  logic [NCH*VADRW-1:0] REG_VRAMADR;
  logic [NCH*8-1:0]     REG_VOLUME;
  logic [NCH-1:0]       REG_LOOP;
  logic [NCH-1:0]       REG_DEM;
  logic [NCH-1:0]       REG_MUTE;
  logic [NCH*32-1:0]    REG_MUSIC;
  logic [NCH*32-1:0]    REG_DELAY;

  snd_regfile_if #(.CHW(CHW)) cif ();

  snd_regfile #(.NCH(NCH), .VADRW(VADRW)) dut (
    .CLK         (CLK),
    .RST_X       (RST_X),
    .cif         (cif),
    .HW_EVENT    (HW_EVENT),
    .HW_FRAME    (HW_FRAME),
    .SND_IRQ     (SND_IRQ),
    .REG_START   (REG_START),
    .REG_CMD     (REG_CMD),
    .REG_VRAMADR (REG_VRAMADR),
    .REG_VOLUME  (REG_VOLUME),
    .REG_LOOP    (REG_LOOP),
    .REG_DEM     (REG_DEM),
    .REG_MUTE    (REG_MUTE),
    .REG_MUSIC   (REG_MUSIC),
    .REG_DELAY   (REG_DELAY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: readable value and driven (active) value of every register, by channel/index.
  logic [31:0]    m_reg [NCH][16];
  logic [31:0]    m_act [NCH][16];
  logic [31:0]    e_rdata;
  logic           e_rvalid;
  logic           e_irq;
  logic [NCH-1:0] e_start;
  int checks;
  int failures;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wbits(input int i);
    case (i)
      0: return 2;
      1: return VADRW;
      2: return 8;
      3: return 1;
      4: return 2;
      5: return 8;
      6: return 32;
      7: return 32;
      8: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] wmask(input int i);
    int w;
    w = wbits(i);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic bit lane0_only(input int i);
    return (i == 0) || (i == 2) || (i == 3) || (i == 4) || (i == 5) || (i == 8);
  endfunction

  function automatic bit shadowed(input int i);
    return (i == 1) || (i == 2) || (i == 4) || (i == 6) || (i == 7);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 16; i++) begin
        m_reg[c][i] = '0;
        m_act[c][i] = '0;
      end
    e_rdata  = '0;
    e_rvalid = 1'b0;
    e_irq    = 1'b0;
    e_start  = '0;
  endtask

  task automatic check_outputs();
    logic [NCH*2-1:0]     x_cmd;
    logic [NCH*VADRW-1:0] x_vram;
    logic [NCH*8-1:0]     x_vol;
    logic [NCH-1:0]       x_loop, x_dem, x_mute;
    logic [NCH*32-1:0]    x_music, x_delay;
    for (int c = 0; c < NCH; c++) begin
      x_cmd[c*2 +: 2]          = m_act[c][0][1:0];
      x_vram[c*VADRW +: VADRW] = m_act[c][1][VADRW-1:0];
      x_vol[c*8 +: 8]          = m_act[c][2][7:0];
      x_loop[c]                = m_act[c][3][0];
      x_dem[c]                 = m_act[c][4][1];
      x_mute[c]                = m_act[c][4][0];
      x_music[c*32 +: 32]      = m_act[c][6];
      x_delay[c*32 +: 32]      = m_act[c][7];
    end
    chk("rvalid", 128'(cif.SND_RVALID), 128'(e_rvalid));
    chk("rdata",  128'(cif.SND_REGRDATA), 128'(e_rdata));
    chk("irq",    128'(SND_IRQ), 128'(e_irq));
    chk("start",  128'(REG_START), 128'(e_start));
    chk("cmd",    128'(REG_CMD), 128'(x_cmd));
    chk("vram",   128'(REG_VRAMADR), 128'(x_vram));
    chk("volume", 128'(REG_VOLUME), 128'(x_vol));
    chk("loop",   128'(REG_LOOP), 128'(x_loop));
    chk("dem",    128'(REG_DEM), 128'(x_dem));
    chk("mute",   128'(REG_MUTE), 128'(x_mute));
    chk("music",  128'(REG_MUSIC), 128'(x_music));
    chk("delay",  128'(REG_DELAY), 128'(x_delay));
  endtask

  // One bus cycle: drive, predict, clock, compare.
  task automatic step(input bit sel, input bit rd, input logic [3:0] be,
                      input logic [5:0] adr, input logic [31:0] wd,
                      input logic [NCH*8-1:0] ev, input logic [NCH-1:0] fr);
    int ch, idx;
    logic [31:0] old [NCH][16];
    logic [31:0] lm;
    logic [7:0]  w1c;
    cif.CIF_SNDSEL   = sel;
    cif.CIF_REGREAD  = rd;
    cif.CIF_REGWRITE = be;
    cif.CIF_REGADR   = adr;
    cif.CIF_REGWDATA = wd;
    HW_EVENT = ev;
    HW_FRAME = fr;
    ch  = int'(adr[5:4]);
    idx = int'(adr[3:0]);
    e_rvalid = sel && rd;
    if (sel && rd) e_rdata = (ch < NCH) ? m_reg[ch][idx] : 32'd0;
    e_irq = 1'b0;
    for (int c = 0; c < NCH; c++)
      if ((m_reg[c][5] & m_reg[c][8]) != 32'd0) e_irq = 1'b1;
    e_start = '0;
    old = m_reg;
    lm = '0;
    for (int n = 0; n < 4; n++)
      if (be[n] && (n == 0 || !lane0_only(idx))) lm[8*n +: 8] = 8'hFF;
    for (int c = 0; c < NCH; c++) begin
      w1c = '0;
      if (sel && be != 4'd0 && c == ch) begin
        if (idx == 5) begin
          if (be[0]) w1c = wd[7:0];
        end else begin
          m_reg[c][idx] = ((m_reg[c][idx] & ~lm) | (wd & lm)) & wmask(idx);
        end
        if (idx == 0 && be[0] && wd[1:0] != 2'd0) e_start[c] = 1'b1;
      end
      m_reg[c][5] = (m_reg[c][5] & ~{24'd0, w1c}) | {24'd0, ev[c*8 +: 8]};
      for (int i = 0; i < 16; i++) begin
        if (SHADOW && shadowed(i)) begin
          if (fr[c]) m_act[c][i] = old[c][i];
        end else begin
          m_act[c][i] = m_reg[c][i];
        end
      end
    end
    @(posedge CLK);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 6'd0, 32'd0, '0, '0);
  endtask

  task automatic wr(input int ch, input int idx, input logic [3:0] be, input logic [31:0] wd);
    step(1'b1, 1'b0, be, {2'(ch), 4'(idx)}, wd, '0, '0);
  endtask

  task automatic rdr(input int ch, input int idx);
    step(1'b1, 1'b1, 4'd0, {2'(ch), 4'(idx)}, 32'd0, '0, '0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST_X    = 1'b0;
    cif.CIF_SNDSEL   = 1'b0;
    cif.CIF_REGREAD  = 1'b0;
    cif.CIF_REGWRITE = '0;
    cif.CIF_REGADR   = '0;
    cif.CIF_REGWDATA = '0;
    HW_EVENT = '0;
    HW_FRAME = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_outputs();
    @(negedge CLK);
    RST_X = 1'b1;

    // Every index of channels 0 and 1 reads zero after reset.
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 16; i++) begin
        rdr(c, i);
        chk("rst_read", 128'(cif.SND_REGRDATA), 128'(0));
        idle();
      end

    // Byte-enable merge on MUSIC of channel 1.
    wr(1, 6, 4'hF, 32'hAABB_CCDD);
    wr(1, 6, 4'h5, 32'h1122_3344);
    rdr(1, 6);
    chk("music_rd", 128'(cif.SND_REGRDATA), 128'(32'hAA22_CC44));
`ifdef SND_REGFILE_SHADOW_EN
    step(1'b0, 1'b0, 4'd0, 6'd0, 32'd0, '0, 3'b010);
`endif
    chk("music_s1", 128'(REG_MUSIC[63:32]), 128'(32'hAA22_CC44));
    chk("music_s0", 128'(REG_MUSIC[31:0]), 128'(0));

    // START strobe on nonzero CMD write only.
    wr(0, 0, 4'h1, 32'h1);
    chk("start_hi", 128'(REG_START[0]), 128'(1));
    chk("cmd_val", 128'(REG_CMD[1:0]), 128'(1));
    idle();
    chk("start_lo", 128'(REG_START[0]), 128'(0));
    wr(0, 0, 4'h1, 32'h0);
    chk("start_zero", 128'(REG_START[0]), 128'(0));

    // Status / IRQ, including set-wins on a coincident clear.
    wr(0, 8, 4'h1, 32'h4);
    step(1'b0, 1'b0, 4'd0, 6'd0, 32'd0, 24'h4, '0);
    chk("irq_pre", 128'(SND_IRQ), 128'(0));
    rdr(0, 5);
    chk("status_rd", 128'(cif.SND_REGRDATA), 128'(4));
    chk("irq_hi", 128'(SND_IRQ), 128'(1));
    step(1'b1, 1'b0, 4'h1, {2'd0, 4'd5}, 32'h4, 24'h4, '0);
    rdr(0, 5);
    chk("status_setwin", 128'(cif.SND_REGRDATA), 128'(4));
    wr(0, 5, 4'h1, 32'h4);
    chk("irq_hold", 128'(SND_IRQ), 128'(1));
    idle();
    chk("irq_clr", 128'(SND_IRQ), 128'(0));

    // Nonexistent channel 3: writes dropped, reads zero.
    wr(3, 4, 4'h1, 32'h3);
    wr(3, 6, 4'hF, 32'hDEAD_BEEF);
    rdr(3, 4);
    chk("badch_rd4", 128'(cif.SND_REGRDATA), 128'(0));
    rdr(3, 6);
    chk("badch_rd6", 128'(cif.SND_REGRDATA), 128'(0));

    // VOLUME visibility with and without shadowing.
    wr(0, 2, 4'h1, 32'h7F);
`ifdef SND_REGFILE_SHADOW_EN
    chk("vol_pre", 128'(REG_VOLUME[7:0]), 128'(0));
    rdr(0, 2);
    chk("vol_rd", 128'(cif.SND_REGRDATA), 128'(32'h7F));
    chk("vol_wait", 128'(REG_VOLUME[7:0]), 128'(0));
    step(1'b0, 1'b0, 4'd0, 6'd0, 32'd0, '0, 3'b001);
    chk("vol_frame", 128'(REG_VOLUME[7:0]), 128'(8'h7F));
`else
    chk("vol_direct", 128'(REG_VOLUME[7:0]), 128'(8'h7F));
    rdr(0, 2);
    chk("vol_rd", 128'(cif.SND_REGRDATA), 128'(32'h7F));
`endif

    // Asynchronous reset mid-operation clears a pending START and read data.
    wr(0, 0, 4'h1, 32'h2);
    chk("start_pre_rst", 128'(REG_START[0]), 128'(1));
    #2;
    RST_X = 1'b0;
    #1;
    chk("rst_start", 128'(REG_START), 128'(0));
    chk("rst_rdata", 128'(cif.SND_REGRDATA), 128'(0));
    chk("rst_cmd", 128'(REG_CMD), 128'(0));
    model_reset();
    @(negedge CLK);
    RST_X = 1'b1;

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      logic [NCH*8-1:0] ev;
      logic [3:0]       be;
      logic [5:0]       adr;
      ev = '0;
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 5) == 0) ev[c*8 +: 8] = 8'(1 << $urandom_range(0, 7));
      be  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      adr = {2'($urandom_range(0, 3)),
             ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8))};
      step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), be, adr,
           $urandom(), ev, 3'($urandom_range(0, 7)));
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
